mdio_responder: RTL and testbench

Clause-22 MDIO management responder: the PHY-side target of the MAC's MDC/MDIO master. It oversamples MDC/MDIO in the sys_clk domain, decodes read/write frames addressed to PHY_ADDR, and serves a 32 x 16 register bank. Used as the PHY-side management model/target behind the bidirectional MDIO pad buffer, and as a loopback responder for management bring-up.

---
 rtl/mdio_responder.sv | 160 ++++++++++++++++
 tb/tb_mdio_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO target serving a 32 x 16 register bank.
// MDC/MDIO are oversampled in the sys_clk domain; all outputs are registered.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1611,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [15:0] status_in,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  typedef enum logic [2:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, DATA
  } state_t;

  localparam logic [5:0] PRE_MIN = 6'(PRE_LEN);

  state_t state, state_nx;

  logic        mdc_s1, mdc_s2, mdc_prev;
  logic        mdio_s1, mdio_s2;
  logic        rise, bit_in, last;
  logic [5:0]  pre_cnt;
  logic [3:0]  bit_cnt;
  logic        is_read, match;
  logic [4:0]  regad;
  logic [14:0] shreg;
  logic [15:0] wr_word, tx, rd_data;
  logic        ro_reg;
  logic [15:0] bank [32];

  assign rise    = mdc_s2 & ~mdc_prev;
  assign bit_in  = mdio_s2;
  assign wr_word = {shreg, bit_in};
  assign ro_reg  = (regad == 5'd1) || (regad == 5'd2) || (regad == 5'd3);

  // Syncs reset to idle-high so a stuck-high MDC never looks like a rise.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      {mdc_s1, mdc_s2, mdc_prev} <= 3'b111;
      {mdio_s1, mdio_s2}         <= 2'b11;
    end else begin
      mdc_s1   <= mdc;
      mdc_s2   <= mdc_s1;
      mdc_prev <= mdc_s2;
      mdio_s1  <= mdio_in;
      mdio_s2  <= mdio_s1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    last     = 1'b0;
    unique case (state)
      ST:      last = 1'b1;
      OP:      last = (bit_cnt == 4'd1);
      PHYAD:   last = (bit_cnt == 4'd4);
      REGAD:   last = (bit_cnt == 4'd4);
      TA:      last = (bit_cnt == 4'd1);
      DATA:    last = (bit_cnt == 4'd15);
      default: last = 1'b0;
    endcase
    if (rise) begin
      unique case (state)
        IDLE:  if (!bit_in && pre_cnt >= PRE_MIN) state_nx = ST;
        ST:    state_nx = bit_in ? OP : IDLE;
        // 10 and 01 are the only legal opcodes
        OP:    if (last) state_nx = (shreg[0] ^ bit_in) ? PHYAD : IDLE;
        PHYAD: if (last) state_nx = REGAD;
        REGAD: if (last) state_nx = TA;
        TA:    if (last) state_nx = DATA;
        DATA:  if (last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = bank[regad];
    unique case (1'b1)
      regad == 5'd1: rd_data = status_in;
      regad == 5'd2: rd_data = PHY_ID1;
      regad == 5'd3: rd_data = PHY_ID2;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      match     <= 1'b0;
      regad     <= '0;
      shreg     <= '0;
      tx        <= '0;
      mdio_out  <= 1'b1;
      mdio_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (rise) begin
        shreg   <= wr_word[14:0];
        bit_cnt <= (state == IDLE || last) ? 4'd0 : bit_cnt + 4'd1;
        if (state == IDLE && bit_in)
          pre_cnt <= (pre_cnt == 6'd63) ? pre_cnt : pre_cnt + 6'd1;
        else
          pre_cnt <= '0;
        unique case (state)
          OP:    if (last) is_read <= shreg[0];
          PHYAD: if (last) match <= (wr_word[4:0] == PHY_ADDR);
          REGAD: if (last) regad <= wr_word[4:0];
          TA: if (is_read && match) begin
            if (!last) begin
              tx       <= rd_data;
              mdio_out <= 1'b0;
              mdio_oe  <= 1'b1;
            end else begin
              mdio_out <= tx[15];
              tx       <= {tx[14:0], 1'b1};
            end
          end
          DATA: if (is_read && match) begin
            if (last) begin
              mdio_out <= 1'b1;
              mdio_oe  <= 1'b0;
            end else begin
              mdio_out <= tx[15];
              tx       <= {tx[14:0], 1'b1};
            end
          end else if (!is_read && match && last) begin
            wr_strobe <= 1'b1;
            wr_addr   <= regad;
            wr_data   <= wr_word;
            if (!ro_reg) bank[regad] <= wr_word;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDC/MDIO master with a pulled-up pad
// and a register-map reference model built from the frame rules.
`timescale 1ns/1ps
module tb_mdio_responder;

  localparam int HALF = 8;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b1;
  logic        mdio_in;
  logic        mdio_out, mdio_oe, wr_strobe;
  logic [15:0] status_in = '0;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  logic        m_en = 1'b1;
  logic        m_bit = 1'b1;
  logic        pad;

  int checks = 0, errors = 0;
  int strobe_hi = 0, contention = 0, oe_rises = 0;
  int chg_at = -1;
  logic [15:0] chg_val = '0;

  logic [15:0] model [32];
  logic [4:0]  exp_addr = '0;
  logic [15:0] exp_data = '0;

  assign pad     = mdio_oe ? mdio_out : (m_en ? m_bit : 1'b1);
  assign mdio_in = pad;

  always #5 sys_clk = ~sys_clk;

  mdio_responder dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe),
    .status_in (status_in),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always @(negedge sys_clk) begin
    if (wr_strobe === 1'b1) strobe_hi++;
    if (mdio_oe === 1'b1 && m_en) contention++;
  end

  function automatic logic [15:0] model_rd(input logic [4:0] ra,
                                           input logic [15:0] st);
    if (ra == 5'd1) return st;
    if (ra == 5'd2) return 16'h0022;
    if (ra == 5'd3) return 16'h1611;
    return model[ra];
  endfunction

  task automatic model_wr(input logic [4:0] ra, input logic [15:0] wd);
    if (ra > 5'd3 || ra == 5'd0) model[ra] = wd;
    exp_addr = ra;
    exp_data = wd;
  endtask

  // One MDC period: master changes data while MDC is low, samples before the rise.
  task automatic mbit(input logic en, input logic v, output logic s);
    mdc   = 1'b0;
    m_en  = en;
    m_bit = v;
    repeat (HALF) @(negedge sys_clk);
    s = pad;
    if (mdio_oe === 1'b1) oe_rises++;
    mdc = 1'b1;
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic frame(input int pre, input logic [1:0] st,
                       input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd,
                       input int ndata, output logic [15:0] rd,
                       output logic ta1, output logic ta2);
    logic s;
    oe_rises = 0;
    rd = '0;
    for (int i = pre; i > 0; i--) mbit(1'b1, 1'b1, s);
    for (int i = 1; i >= 0; i--) mbit(1'b1, st[i], s);
    for (int i = 1; i >= 0; i--) mbit(1'b1, op[i], s);
    for (int i = 4; i >= 0; i--) mbit(1'b1, phy[i], s);
    for (int i = 4; i >= 0; i--) mbit(1'b1, ra[i], s);
    if (op == 2'b10) begin
      mbit(1'b0, 1'b1, ta1);
      mbit(1'b0, 1'b1, ta2);
      for (int i = 0; i < ndata; i++) begin
        if (i == chg_at) status_in = chg_val;
        mbit(1'b0, 1'b1, s);
        rd = {rd[14:0], s};
      end
    end else begin
      mbit(1'b1, 1'b1, ta1);
      mbit(1'b1, 1'b0, ta2);
      for (int i = 15; i >= 0; i--) mbit(1'b1, wd[i], s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 32; i++) model[i] = '0;
    checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", mdio_oe); end
    checks++; if (mdio_out !== 1'b1) begin errors++; $display("FAIL reset_out got %b exp 1", mdio_out); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", wr_strobe); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", wr_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0", wr_data); end
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_write_read();
    logic [15:0] rd;
    logic t1, t2;
    int s0;
    s0 = strobe_hi;
    frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hA5C3, 16, rd, t1, t2);
    model_wr(5'd4, 16'hA5C3);
    checks++; if (strobe_hi - s0 != 1) begin errors++; $display("FAIL wr_strobe_cycles got %0d exp 1", strobe_hi - s0); end
    checks++; if (wr_addr !== 5'd4) begin errors++; $display("FAIL wr_addr got %h exp 4", wr_addr); end
    checks++; if (wr_data !== 16'hA5C3) begin errors++; $display("FAIL wr_data got %h exp a5c3", wr_data); end
    frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16, rd, t1, t2);
    checks++; if (rd !== model_rd(5'd4, status_in)) begin errors++; $display("FAIL rd_reg4 got %h exp %h", rd, model_rd(5'd4, status_in)); end
    checks++; if (oe_rises != 17) begin errors++; $display("FAIL rd_oe_rises got %0d exp 17", oe_rises); end
    checks++; if (t1 !== 1'b1) begin errors++; $display("FAIL rd_ta1 got %b exp 1", t1); end
    checks++; if (t2 !== 1'b0) begin errors++; $display("FAIL rd_ta2 got %b exp 0", t2); end
  endtask

  task automatic test_id_regs();
    logic [15:0] rd;
    logic t1, t2;
    for (int r = 2; r <= 3; r++) begin
      frame(32, 2'b01, 2'b10, 5'd1, 5'(r), 16'h0, 16, rd, t1, t2);
      checks++; if (rd !== model_rd(5'(r), status_in)) begin errors++; $display("FAIL id_reg%0d got %h exp %h", r, rd, model_rd(5'(r), status_in)); end
      checks++; if (t1 !== 1'b1 || t2 !== 1'b0) begin errors++; $display("FAIL id_ta%0d got %b%b exp 10", r, t1, t2); end
    end
  endtask

  task automatic test_status();
    logic [15:0] rd, expv;
    logic t1, t2;
    int s0;
    status_in = 16'h796D;
    expv = model_rd(5'd1, status_in);
    chg_at = 4;
    chg_val = 16'h0000;
    frame(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, 16, rd, t1, t2);
    chg_at = -1;
    checks++; if (rd !== expv) begin errors++; $display("FAIL status_capture got %h exp %h", rd, expv); end
    s0 = strobe_hi;
    frame(32, 2'b01, 2'b01, 5'd1, 5'd2, 16'hBEEF, 16, rd, t1, t2);
    model_wr(5'd2, 16'hBEEF);
    checks++; if (strobe_hi - s0 != 1) begin errors++; $display("FAIL ro_strobe got %0d exp 1", strobe_hi - s0); end
    checks++; if (wr_addr !== exp_addr || wr_data !== exp_data) begin errors++; $display("FAIL ro_wr got %h/%h exp %h/%h", wr_addr, wr_data, exp_addr, exp_data); end
    frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 16, rd, t1, t2);
    checks++; if (rd !== model_rd(5'd2, status_in)) begin errors++; $display("FAIL ro_read got %h exp %h", rd, model_rd(5'd2, status_in)); end
  endtask

  task automatic test_mismatch();
    logic [15:0] rd;
    logic t1, t2;
    int s0;
    s0 = strobe_hi;
    frame(32, 2'b01, 2'b10, 5'd2, 5'd4, 16'h0, 16, rd, t1, t2);
    checks++; if (oe_rises != 0) begin errors++; $display("FAIL mis_rd_oe got %0d exp 0", oe_rises); end
    frame(32, 2'b01, 2'b01, 5'd2, 5'd4, 16'h1111, 16, rd, t1, t2);
    checks++; if (strobe_hi != s0) begin errors++; $display("FAIL mis_wr_strobe got %0d exp 0", strobe_hi - s0); end
    checks++; if (wr_data !== exp_data) begin errors++; $display("FAIL mis_wr_data got %h exp %h", wr_data, exp_data); end
    frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16, rd, t1, t2);
    checks++; if (rd !== model_rd(5'd4, status_in)) begin errors++; $display("FAIL mis_reg4 got %h exp %h", rd, model_rd(5'd4, status_in)); end
  endtask

  task automatic test_malformed();
    int pres [4] = '{31, 32, 32, 31};
    logic [1:0] sts [4] = '{2'b01, 2'b00, 2'b01, 2'b01};
    logic [1:0] ops [4] = '{2'b01, 2'b01, 2'b11, 2'b10};
    logic [15:0] rd;
    logic t1, t2;
    int s0;
    for (int k = 0; k < 4; k++) begin
      s0 = strobe_hi;
      frame(pres[k], sts[k], ops[k], 5'd1, 5'd4, 16'h1234, 16, rd, t1, t2);
      checks++; if (oe_rises != 0 || strobe_hi != s0) begin errors++; $display("FAIL bad_frame%0d oe %0d strobe %0d exp 0 0", k, oe_rises, strobe_hi - s0); end
    end
    frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16, rd, t1, t2);
    checks++; if (rd !== model_rd(5'd4, status_in) || oe_rises != 17) begin errors++; $display("FAIL bad_recover got %h/%0d exp %h/17", rd, oe_rises, model_rd(5'd4, status_in)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic rd_op, hit, t1, t2;
      logic [4:0] phy, ra;
      logic [15:0] wd, rd, expv;
      int s0;
      rd_op = 1'($urandom_range(0, 1));
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
      hit = (phy == 5'd1);
      ra = 5'($urandom_range(0, 7));
      wd = 16'($urandom);
      status_in = 16'($urandom);
      if (rd_op) begin
        expv = model_rd(ra, status_in);
        frame(32, 2'b01, 2'b10, phy, ra, 16'h0, 16, rd, t1, t2);
        checks++; if (oe_rises != (hit ? 17 : 0)) begin errors++; $display("FAIL rnd%0d_oe got %0d exp %0d", n, oe_rises, hit ? 17 : 0); end
        if (hit) begin
          checks++; if (rd !== expv) begin errors++; $display("FAIL rnd%0d_rd reg %0d got %h exp %h", n, ra, rd, expv); end
        end
      end else begin
        s0 = strobe_hi;
        frame(32, 2'b01, 2'b01, phy, ra, wd, 16, rd, t1, t2);
        if (hit) model_wr(ra, wd);
        checks++; if (strobe_hi - s0 != (hit ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_strobe got %0d exp %0d", n, strobe_hi - s0, hit ? 1 : 0); end
        checks++; if (wr_addr !== exp_addr || wr_data !== exp_data) begin errors++; $display("FAIL rnd%0d_wr got %h/%h exp %h/%h", n, wr_addr, wr_data, exp_addr, exp_data); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic t1, t2;
    frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h5A5A, 16, rd, t1, t2);
    model_wr(5'd4, 16'h5A5A);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 9, rd, t1, t2);
    @(negedge sys_clk);
    checks++; if (mdio_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before got %b exp 1", mdio_oe); end
    rst = 1'b1;
    @(negedge sys_clk);
    checks++; if (mdio_oe !== 1'b0 || mdio_out !== 1'b1) begin errors++; $display("FAIL mid_release got oe %b out %b exp 0 1", mdio_oe, mdio_out); end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_addr = '0;
    exp_data = '0;
    checks++; if (wr_addr !== exp_addr || wr_data !== exp_data) begin errors++; $display("FAIL mid_wr_regs got %h/%h exp 0/0", wr_addr, wr_data); end
    @(negedge sys_clk);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, 16, rd, t1, t2);
    checks++; if (rd !== model_rd(5'd4, status_in) || oe_rises != 17) begin errors++; $display("FAIL mid_reg4 got %h/%0d exp %h/17", rd, oe_rises, model_rd(5'd4, status_in)); end
    frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, 16, rd, t1, t2);
    checks++; if (rd !== model_rd(5'd2, status_in)) begin errors++; $display("FAIL mid_reg2 got %h exp %h", rd, model_rd(5'd2, status_in)); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id_regs();
    test_status();
    test_mismatch();
    test_malformed();
    test_random();
    test_reset_mid();
    checks++; if (contention != 0) begin errors++; $display("FAIL bus_contention got %0d exp 0", contention); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
